// File: rtl/cpu_pkg.sv
// Shared definitions for the control unit: state encodings, instruction
// classes, opcode constants and the bit map of the packed ctrl strobe bus.
package cpu_pkg;

    typedef enum logic [3:0] {
        S_RESET = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_T3    = 4'd4,
        S_T4    = 4'd5,
        S_T5    = 4'd6,
        S_T6    = 4'd7,
        S_T7    = 4'd8,
        S_HALT  = 4'd9
    } state_t;

    typedef enum logic [3:0] {
        C_NONE   = 4'd0,
        C_ALU_R  = 4'd1,
        C_ALU_I  = 4'd2,
        C_UNARY  = 4'd3,
        C_MULDIV = 4'd4,
        C_LD     = 4'd5,
        C_LDI    = 4'd6,
        C_ST     = 4'd7,
        C_BR     = 4'd8,
        C_MFHI   = 4'd9,
        C_MFLO   = 4'd10,
        C_IN     = 4'd11,
        C_OUT    = 4'd12,
        C_HALT   = 4'd13
    } iclass_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0]  ALU_NONE  = 5'b00000;
    localparam logic [27:0] CTRL_NONE = 28'd0;

    localparam int unsigned B_PC_OUT       = 0;
    localparam int unsigned B_ZHIGH_OUT    = 1;
    localparam int unsigned B_ZLOW_OUT     = 2;
    localparam int unsigned B_HI_OUT       = 3;
    localparam int unsigned B_LO_OUT       = 4;
    localparam int unsigned B_C_OUT        = 5;
    localparam int unsigned B_MDR_OUT      = 6;
    localparam int unsigned B_IN_PORT_OUT  = 7;
    localparam int unsigned B_BA_OUT       = 8;
    localparam int unsigned B_R_OUT        = 9;
    localparam int unsigned B_MAR_EN       = 10;
    localparam int unsigned B_MDR_EN       = 11;
    localparam int unsigned B_Z_EN         = 12;
    localparam int unsigned B_Y_EN         = 13;
    localparam int unsigned B_PC_EN        = 14;
    localparam int unsigned B_LO_EN        = 15;
    localparam int unsigned B_HI_EN        = 16;
    localparam int unsigned B_IR_EN        = 17;
    localparam int unsigned B_R_IN         = 18;
    localparam int unsigned B_INC_PC       = 19;
    localparam int unsigned B_READ         = 20;
    localparam int unsigned B_RAM_WE       = 21;
    localparam int unsigned B_CON_IN       = 22;
    localparam int unsigned B_OUT_PORT_EN  = 23;
    localparam int unsigned B_GRA          = 24;
    localparam int unsigned B_GRB          = 25;
    localparam int unsigned B_GRC          = 26;
    localparam int unsigned B_SPARE        = 27;

endpackage

// File: rtl/op_decode.sv
// Combinational opcode decoder: instruction class, ALU operation and the
// final execute step after which the control unit returns to T0.
module op_decode
    import cpu_pkg::*;
(
    input  logic [4:0] i_opcode,
    output iclass_t    o_class,
    output logic [4:0] o_alu_op,
    output state_t     o_last
);

    // Classify the opcode; anything unrecognised is treated as a no-op.
    always_comb begin
        o_class  = C_NONE;
        o_alu_op = ALU_NONE;
        o_last   = S_T2;
        case (i_opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL: begin
                o_class  = C_ALU_R;
                o_alu_op = i_opcode;
                o_last   = S_T5;
            end
            OP_ADDI: begin o_class = C_ALU_I; o_alu_op = OP_ADD; o_last = S_T5; end
            OP_ANDI: begin o_class = C_ALU_I; o_alu_op = OP_AND; o_last = S_T5; end
            OP_ORI:  begin o_class = C_ALU_I; o_alu_op = OP_OR;  o_last = S_T5; end
            OP_NEG, OP_NOT: begin
                o_class  = C_UNARY;
                o_alu_op = i_opcode;
                o_last   = S_T4;
            end
            OP_MUL, OP_DIV: begin
                o_class  = C_MULDIV;
                o_alu_op = i_opcode;
                o_last   = S_T6;
            end
            // Memory and branch ops all form an address/target with add.
            OP_LD:   begin o_class = C_LD;   o_alu_op = OP_ADD; o_last = S_T7; end
            OP_LDI:  begin o_class = C_LDI;  o_alu_op = OP_ADD; o_last = S_T5; end
            OP_ST:   begin o_class = C_ST;   o_alu_op = OP_ADD; o_last = S_T7; end
            OP_BR:   begin o_class = C_BR;   o_alu_op = OP_ADD; o_last = S_T6; end
            OP_MFHI: begin o_class = C_MFHI; o_last = S_T3; end
            OP_MFLO: begin o_class = C_MFLO; o_last = S_T3; end
            OP_IN:   begin o_class = C_IN;   o_last = S_T3; end
            OP_OUT:  begin o_class = C_OUT;  o_last = S_T3; end
            OP_HALT: begin o_class = C_HALT; o_last = S_HALT; end
            default: begin
                o_class  = C_NONE;
                o_alu_op = ALU_NONE;
                o_last   = S_T2;
            end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Moore-style control unit: fetch T0-T2, class-dependent execute T3-T7,
// HALT until reset. Strobes are decoded from the state and latched opcode.
module control_unit
    import cpu_pkg::*;
(
    input  logic        Clock,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        CON_FF,
    output logic [27:0] ctrl,
    output logic [4:0]  alu_op,
    output logic        Run,
    output logic [3:0]  state
);

    state_t      r_state;
    state_t      w_next;
    state_t      w_last;
    iclass_t     w_class;
    logic [4:0]  r_opcode;
    logic [4:0]  w_dec_opcode;
    logic [4:0]  w_dec_alu;
    logic [27:0] w_ctrl;
    logic [4:0]  w_alu;
    logic        w_run;
    logic        w_unused_ir;

    assign w_unused_ir = ^IR[26:0];

    // During T2 the opcode is not latched yet, so branch on the live IR field.
    assign w_dec_opcode = (r_state == S_T2) ? IR[31:27] : r_opcode;

    op_decode u_op_decode (
        .i_opcode (w_dec_opcode),
        .o_class  (w_class),
        .o_alu_op (w_dec_alu),
        .o_last   (w_last)
    );

    // State and opcode registers.
    always_ff @(posedge Clock or negedge clr) begin
        if (!clr) begin
            r_state  <= S_RESET;
            r_opcode <= 5'b00000;
        end else begin
            r_state <= w_next;
            if (r_state == S_T2) begin
                r_opcode <= IR[31:27];
            end
        end
    end

    // Next-state sequencing.
    always_comb begin
        w_next = S_RESET;
        case (r_state)
            S_RESET: w_next = S_T0;
            S_T0:    w_next = S_T1;
            S_T1:    w_next = S_T2;
            S_T2: begin
                if (w_class == C_HALT) begin
                    w_next = S_HALT;
                end else if (w_class == C_NONE) begin
                    w_next = S_T0;
                end else begin
                    w_next = S_T3;
                end
            end
            S_T3:    w_next = (w_last == S_T3) ? S_T0 : S_T4;
            S_T4:    w_next = (w_last == S_T4) ? S_T0 : S_T5;
            S_T5:    w_next = (w_last == S_T5) ? S_T0 : S_T6;
            S_T6:    w_next = (w_last == S_T6) ? S_T0 : S_T7;
            S_T7:    w_next = S_T0;
            S_HALT:  w_next = S_HALT;
            default: w_next = S_RESET;
        endcase
    end

    // Strobe decode; each state enables at most one bus driver.
    always_comb begin
        w_ctrl = CTRL_NONE;
        w_alu  = ALU_NONE;
        w_run  = 1'b1;
        case (r_state)
            S_T0: begin
                w_ctrl[B_PC_OUT] = 1'b1; w_ctrl[B_MAR_EN] = 1'b1; w_ctrl[B_INC_PC] = 1'b1;
            end
            S_T1: begin
                w_ctrl[B_READ] = 1'b1; w_ctrl[B_MDR_EN] = 1'b1;
            end
            S_T2: begin
                w_ctrl[B_MDR_OUT] = 1'b1; w_ctrl[B_IR_EN] = 1'b1;
            end
            S_T3: begin
                case (w_class)
                    C_ALU_R: begin
                        w_ctrl[B_GRB] = 1'b1; w_ctrl[B_R_OUT] = 1'b1; w_ctrl[B_Y_EN] = 1'b1;
                    end
                    C_ALU_I, C_LD, C_LDI, C_ST: begin
                        w_ctrl[B_GRB] = 1'b1; w_ctrl[B_BA_OUT] = 1'b1; w_ctrl[B_Y_EN] = 1'b1;
                    end
                    C_UNARY: begin
                        w_ctrl[B_GRB] = 1'b1; w_ctrl[B_R_OUT] = 1'b1; w_ctrl[B_Z_EN] = 1'b1;
                        w_alu = w_dec_alu;
                    end
                    C_MULDIV: begin
                        w_ctrl[B_GRA] = 1'b1; w_ctrl[B_R_OUT] = 1'b1; w_ctrl[B_Y_EN] = 1'b1;
                    end
                    C_BR: begin
                        w_ctrl[B_GRA] = 1'b1; w_ctrl[B_R_OUT] = 1'b1; w_ctrl[B_CON_IN] = 1'b1;
                    end
                    C_MFHI: begin
                        w_ctrl[B_HI_OUT] = 1'b1; w_ctrl[B_GRA] = 1'b1; w_ctrl[B_R_IN] = 1'b1;
                    end
                    C_MFLO: begin
                        w_ctrl[B_LO_OUT] = 1'b1; w_ctrl[B_GRA] = 1'b1; w_ctrl[B_R_IN] = 1'b1;
                    end
                    C_IN: begin
                        w_ctrl[B_IN_PORT_OUT] = 1'b1; w_ctrl[B_GRA] = 1'b1; w_ctrl[B_R_IN] = 1'b1;
                    end
                    C_OUT: begin
                        w_ctrl[B_GRA] = 1'b1; w_ctrl[B_R_OUT] = 1'b1; w_ctrl[B_OUT_PORT_EN] = 1'b1;
                    end
                    default: w_ctrl = CTRL_NONE;
                endcase
            end
            S_T4: begin
                case (w_class)
                    C_ALU_R: begin
                        w_ctrl[B_GRC] = 1'b1; w_ctrl[B_R_OUT] = 1'b1; w_ctrl[B_Z_EN] = 1'b1;
                        w_alu = w_dec_alu;
                    end
                    C_ALU_I, C_LD, C_LDI, C_ST: begin
                        w_ctrl[B_C_OUT] = 1'b1; w_ctrl[B_Z_EN] = 1'b1;
                        w_alu = w_dec_alu;
                    end
                    C_UNARY: begin
                        w_ctrl[B_ZLOW_OUT] = 1'b1; w_ctrl[B_GRA] = 1'b1; w_ctrl[B_R_IN] = 1'b1;
                    end
                    C_MULDIV: begin
                        w_ctrl[B_GRB] = 1'b1; w_ctrl[B_R_OUT] = 1'b1; w_ctrl[B_Z_EN] = 1'b1;
                        w_alu = w_dec_alu;
                    end
                    C_BR: begin
                        w_ctrl[B_PC_OUT] = 1'b1; w_ctrl[B_Y_EN] = 1'b1;
                    end
                    default: w_ctrl = CTRL_NONE;
                endcase
            end
            S_T5: begin
                case (w_class)
                    C_ALU_R, C_ALU_I, C_LDI: begin
                        w_ctrl[B_ZLOW_OUT] = 1'b1; w_ctrl[B_GRA] = 1'b1; w_ctrl[B_R_IN] = 1'b1;
                    end
                    C_LD, C_ST: begin
                        w_ctrl[B_ZLOW_OUT] = 1'b1; w_ctrl[B_MAR_EN] = 1'b1;
                    end
                    C_MULDIV: begin
                        w_ctrl[B_ZLOW_OUT] = 1'b1; w_ctrl[B_LO_EN] = 1'b1;
                    end
                    C_BR: begin
                        w_ctrl[B_C_OUT] = 1'b1; w_ctrl[B_Z_EN] = 1'b1;
                        w_alu = w_dec_alu;
                    end
                    default: w_ctrl = CTRL_NONE;
                endcase
            end
            S_T6: begin
                case (w_class)
                    C_MULDIV: begin
                        w_ctrl[B_ZHIGH_OUT] = 1'b1; w_ctrl[B_HI_EN] = 1'b1;
                    end
                    C_LD: begin
                        w_ctrl[B_READ] = 1'b1; w_ctrl[B_MDR_EN] = 1'b1;
                    end
                    C_ST: begin
                        w_ctrl[B_GRA] = 1'b1; w_ctrl[B_R_OUT] = 1'b1; w_ctrl[B_MDR_EN] = 1'b1;
                    end
                    C_BR: begin
                        w_ctrl[B_ZLOW_OUT] = 1'b1; w_ctrl[B_PC_EN] = CON_FF;
                    end
                    default: w_ctrl = CTRL_NONE;
                endcase
            end
            S_T7: begin
                case (w_class)
                    C_LD: begin
                        w_ctrl[B_MDR_OUT] = 1'b1; w_ctrl[B_GRA] = 1'b1; w_ctrl[B_R_IN] = 1'b1;
                    end
                    C_ST:    w_ctrl[B_RAM_WE] = 1'b1;
                    default: w_ctrl = CTRL_NONE;
                endcase
            end
            S_HALT:  w_run  = 1'b0;
            default: w_ctrl = CTRL_NONE;
        endcase
    end

    assign ctrl   = w_ctrl;
    assign alu_op = w_alu;
    assign Run    = w_run;
    assign state  = r_state;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-scenario tasks push expected
// {state, ctrl, alu_op, Run} per cycle into a queue and pop them as the DUT steps.
module tb_control_unit;
    import cpu_pkg::*;

    typedef struct packed {
        logic [3:0]  st;
        logic [27:0] ctrl;
        logic [4:0]  alu;
        logic        run;
    } exp_t;

    logic        Clock;
    logic        clr;
    logic [31:0] IR;
    logic        CON_FF;
    logic [27:0] ctrl;
    logic [4:0]  alu_op;
    logic        Run;
    logic [3:0]  state;

    int   total;
    int   bad;
    exp_t sb[$];

    localparam logic [4:0] R_OPS [0:8] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110,
                                           5'b00111, 5'b01000, 5'b01001, 5'b01010, 5'b01011};

    control_unit dut (
        .Clock  (Clock),
        .clr    (clr),
        .IR     (IR),
        .CON_FF (CON_FF),
        .ctrl   (ctrl),
        .alu_op (alu_op),
        .Run    (Run),
        .state  (state)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got state=%0d want finish", state);
        $fatal(1, "watchdog");
    end

    function automatic logic [27:0] cb(input int a = -1, input int b = -1, input int c = -1);
        logic [27:0] v;
        v = 28'd0;
        if (a >= 0) v[a] = 1'b1;
        if (b >= 0) v[b] = 1'b1;
        if (c >= 0) v[c] = 1'b1;
        return v;
    endfunction

    function automatic void push(input logic [3:0] s, input logic [27:0] c,
                                 input logic [4:0] a = 5'b00000, input logic r = 1'b1);
        exp_t e;
        e = {s, c, a, r};
        sb.push_back(e);
    endfunction

    function automatic void push_fetch();
        push(4'd1, cb(B_PC_OUT, B_MAR_EN, B_INC_PC));
        push(4'd2, cb(B_READ, B_MDR_EN));
        push(4'd3, cb(B_MDR_OUT, B_IR_EN));
    endfunction

    task automatic test_reset();
        @(negedge Clock);
        total++;
        if ({state, ctrl, alu_op, Run} !== {4'd0, 28'd0, 5'd0, 1'b1}) begin
            bad++;
            $display("FAIL reset_state: got %h want %h", {state, ctrl, alu_op, Run}, {4'd0, 28'd0, 5'd0, 1'b1});
        end
        clr = 1'b1;
        @(negedge Clock);
        total++;
        if (state !== 4'd1) begin
            bad++;
            $display("FAIL reset_exit: got state %0d want 1", state);
        end
    endtask

    task automatic test_alu_r();
        exp_t e;
        for (int i = 0; i < 9; i++) begin
            IR = {R_OPS[i], 27'h5A5A5A5};
            push_fetch();
            push(4'd4, cb(B_GRB, B_R_OUT, B_Y_EN));
            push(4'd5, cb(B_GRC, B_R_OUT, B_Z_EN), R_OPS[i]);
            push(4'd6, cb(B_ZLOW_OUT, B_GRA, B_R_IN));
            while (sb.size() > 0) begin
                e = sb.pop_front();
                total++;
                if ({state, ctrl, alu_op, Run} !== e) begin
                    bad++;
                    $display("FAIL alu_r op=%b st%0d: got %h want %h", R_OPS[i], e.st, {state, ctrl, alu_op, Run}, e);
                end
                @(negedge Clock);
            end
            total++;
            if (state !== 4'd1) begin
                bad++;
                $display("FAIL alu_r_end: got state %0d want 1", state);
            end
        end
    endtask

    task automatic test_imm();
        exp_t e;
        logic [31:0] irs [0:2];
        logic [4:0]  alus [0:2];
        irs[0] = 32'h61180005; alus[0] = 5'b00011;
        irs[1] = 32'h69180007; alus[1] = 5'b00101;
        irs[2] = 32'h7118FFFF; alus[2] = 5'b00110;
        for (int i = 0; i < 3; i++) begin
            IR = irs[i];
            push_fetch();
            push(4'd4, cb(B_GRB, B_BA_OUT, B_Y_EN));
            push(4'd5, cb(B_C_OUT, B_Z_EN), alus[i]);
            push(4'd6, cb(B_ZLOW_OUT, B_GRA, B_R_IN));
            while (sb.size() > 0) begin
                e = sb.pop_front();
                total++;
                if ({state, ctrl, alu_op, Run} !== e) begin
                    bad++;
                    $display("FAIL imm ir=%h st%0d: got %h want %h", irs[i], e.st, {state, ctrl, alu_op, Run}, e);
                end
                @(negedge Clock);
            end
            total++;
            if (state !== 4'd1) begin
                bad++;
                $display("FAIL imm_end: got state %0d want 1", state);
            end
        end
    endtask

    task automatic test_unary_muldiv();
        exp_t e;
        logic [4:0] ops [0:3];
        ops[0] = 5'b10001; ops[1] = 5'b10010; ops[2] = 5'b01111; ops[3] = 5'b10000;
        for (int i = 0; i < 4; i++) begin
            IR = {ops[i], 27'h1234567};
            push_fetch();
            if (i < 2) begin
                push(4'd4, cb(B_GRB, B_R_OUT, B_Z_EN), ops[i]);
                push(4'd5, cb(B_ZLOW_OUT, B_GRA, B_R_IN));
            end else begin
                push(4'd4, cb(B_GRA, B_R_OUT, B_Y_EN));
                push(4'd5, cb(B_GRB, B_R_OUT, B_Z_EN), ops[i]);
                push(4'd6, cb(B_ZLOW_OUT, B_LO_EN));
                push(4'd7, cb(B_ZHIGH_OUT, B_HI_EN));
            end
            while (sb.size() > 0) begin
                e = sb.pop_front();
                total++;
                if ({state, ctrl, alu_op, Run} !== e) begin
                    bad++;
                    $display("FAIL unary_muldiv op=%b st%0d: got %h want %h", ops[i], e.st, {state, ctrl, alu_op, Run}, e);
                end
                @(negedge Clock);
            end
            total++;
            if (state !== 4'd1) begin
                bad++;
                $display("FAIL unary_muldiv_end: got state %0d want 1", state);
            end
        end
    endtask

    task automatic test_mem();
        exp_t e;
        logic [4:0] ops [0:2];
        ops[0] = 5'b00000; ops[1] = 5'b00001; ops[2] = 5'b00010;
        for (int i = 0; i < 3; i++) begin
            IR = {ops[i], 27'h0800010};
            push_fetch();
            push(4'd4, cb(B_GRB, B_BA_OUT, B_Y_EN));
            push(4'd5, cb(B_C_OUT, B_Z_EN), 5'b00011);
            if (i == 1) begin
                push(4'd6, cb(B_ZLOW_OUT, B_GRA, B_R_IN));
            end else if (i == 0) begin
                push(4'd6, cb(B_ZLOW_OUT, B_MAR_EN));
                push(4'd7, cb(B_READ, B_MDR_EN));
                push(4'd8, cb(B_MDR_OUT, B_GRA, B_R_IN));
            end else begin
                push(4'd6, cb(B_ZLOW_OUT, B_MAR_EN));
                push(4'd7, cb(B_GRA, B_R_OUT, B_MDR_EN));
                push(4'd8, cb(B_RAM_WE));
            end
            while (sb.size() > 0) begin
                e = sb.pop_front();
                total++;
                if ({state, ctrl, alu_op, Run} !== e) begin
                    bad++;
                    $display("FAIL mem op=%b st%0d: got %h want %h", ops[i], e.st, {state, ctrl, alu_op, Run}, e);
                end
                @(negedge Clock);
            end
            total++;
            if (state !== 4'd1) begin
                bad++;
                $display("FAIL mem_end: got state %0d want 1", state);
            end
        end
    endtask

    task automatic test_br();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            IR = {5'b10011, 27'h0A00004};
            CON_FF = (i == 1);
            push_fetch();
            push(4'd4, cb(B_GRA, B_R_OUT, B_CON_IN));
            push(4'd5, cb(B_PC_OUT, B_Y_EN));
            push(4'd6, cb(B_C_OUT, B_Z_EN), 5'b00011);
            push(4'd7, (i == 1) ? cb(B_ZLOW_OUT, B_PC_EN) : cb(B_ZLOW_OUT));
            while (sb.size() > 0) begin
                e = sb.pop_front();
                total++;
                if ({state, ctrl, alu_op, Run} !== e) begin
                    bad++;
                    $display("FAIL br con=%0d st%0d: got %h want %h", i, e.st, {state, ctrl, alu_op, Run}, e);
                end
                @(negedge Clock);
            end
            total++;
            if (state !== 4'd1) begin
                bad++;
                $display("FAIL br_end: got state %0d want 1", state);
            end
        end
        CON_FF = 1'b0;
    endtask

    task automatic test_io_undef();
        exp_t e;
        logic [4:0] ops [0:5];
        ops[0] = 5'b11000; ops[1] = 5'b11001; ops[2] = 5'b10110;
        ops[3] = 5'b10111; ops[4] = 5'b11111; ops[5] = 5'b11010;
        for (int i = 0; i < 6; i++) begin
            IR = {ops[i], 27'h0C00000};
            push_fetch();
            case (i)
                0: push(4'd4, cb(B_HI_OUT, B_GRA, B_R_IN));
                1: push(4'd4, cb(B_LO_OUT, B_GRA, B_R_IN));
                2: push(4'd4, cb(B_IN_PORT_OUT, B_GRA, B_R_IN));
                3: push(4'd4, cb(B_GRA, B_R_OUT, B_OUT_PORT_EN));
                default: ;
            endcase
            while (sb.size() > 0) begin
                e = sb.pop_front();
                total++;
                if ({state, ctrl, alu_op, Run} !== e) begin
                    bad++;
                    $display("FAIL io_undef op=%b st%0d: got %h want %h", ops[i], e.st, {state, ctrl, alu_op, Run}, e);
                end
                @(negedge Clock);
            end
            total++;
            if (state !== 4'd1 || ctrl[B_R_IN] !== 1'b0 || ctrl[B_RAM_WE] !== 1'b0) begin
                bad++;
                $display("FAIL io_undef_end op=%b: got state %0d ctrl %h want state 1", ops[i], state, ctrl);
            end
        end
    endtask

    task automatic test_clr_mid();
        exp_t e;
        IR = {5'b00000, 27'h0800010};
        push_fetch();
        push(4'd4, cb(B_GRB, B_BA_OUT, B_Y_EN));
        push(4'd5, cb(B_C_OUT, B_Z_EN), 5'b00011);
        push(4'd6, cb(B_ZLOW_OUT, B_MAR_EN));
        while (sb.size() > 1) begin
            e = sb.pop_front();
            total++;
            if ({state, ctrl, alu_op, Run} !== e) begin
                bad++;
                $display("FAIL clr_mid st%0d: got %h want %h", e.st, {state, ctrl, alu_op, Run}, e);
            end
            @(negedge Clock);
        end
        e = sb.pop_front();
        total++;
        if ({state, ctrl, alu_op, Run} !== e) begin
            bad++;
            $display("FAIL clr_mid_t5: got %h want %h", {state, ctrl, alu_op, Run}, e);
        end
        clr = 1'b0;
        #1;
        total++;
        if ({state, ctrl, alu_op, Run} !== {4'd0, 28'd0, 5'd0, 1'b1}) begin
            bad++;
            $display("FAIL clr_mid_async: got %h want %h", {state, ctrl, alu_op, Run}, {4'd0, 28'd0, 5'd0, 1'b1});
        end
        @(posedge Clock);
        #1;
        total++;
        if (state !== 4'd0 || ctrl[B_R_IN] !== 1'b0) begin
            bad++;
            $display("FAIL clr_mid_hold: got state %0d R_in %b want 0 0", state, ctrl[B_R_IN]);
        end
        @(negedge Clock);
        clr = 1'b1;
        @(negedge Clock);
        total++;
        if (state !== 4'd1) begin
            bad++;
            $display("FAIL clr_mid_restart: got state %0d want 1", state);
        end
    endtask

    task automatic test_halt();
        exp_t e;
        IR = {5'b11011, 27'h0000000};
        push_fetch();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if ({state, ctrl, alu_op, Run} !== e) begin
                bad++;
                $display("FAIL halt_fetch st%0d: got %h want %h", e.st, {state, ctrl, alu_op, Run}, e);
            end
            @(negedge Clock);
        end
        for (int i = 0; i < 20; i++) begin
            total++;
            if ({state, ctrl, alu_op, Run} !== {4'd9, 28'd0, 5'd0, 1'b0}) begin
                bad++;
                $display("FAIL halt_hold cyc%0d: got %h want %h", i, {state, ctrl, alu_op, Run}, {4'd9, 28'd0, 5'd0, 1'b0});
            end
            @(negedge Clock);
        end
        clr = 1'b0;
        #1;
        total++;
        if ({state, Run} !== {4'd0, 1'b1}) begin
            bad++;
            $display("FAIL halt_clr: got state %0d Run %b want 0 1", state, Run);
        end
        #2;
        clr = 1'b1;
        @(negedge Clock);
        total++;
        if (state !== 4'd1) begin
            bad++;
            $display("FAIL halt_restart: got state %0d want 1", state);
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        clr    = 1'b0;
        IR     = 32'h00000000;
        CON_FF = 1'b0;
        test_reset();
        test_imm();
        test_alu_r();
        test_unary_muldiv();
        test_mem();
        test_br();
        test_io_undef();
        test_clr_mid();
        test_halt();
        test_imm();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port: Clock  in  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port: clr  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: IR  in  32  instruction register contents; opcode = IR[31:27].
REQ-004 SHALL have port: CON_FF  in  1  branch-condition flag from datapath.
REQ-005 SHALL have port: ctrl  out  28  packed datapath strobes; bit map in package (PC_out, ZHigh_out, ZLow_out, HI_out, LO_out, C_out, MDR_out, in_port_out, BA_out, R_out, MAR_enable, MDR_enable, Z_enable, Y_enable, PC_enable, LO_enable, HI_enable, IR_enable, R_in, IncPC, Read, RAM_write_enable, con_in, out_port_enable, Gra, Grb, Grc, spare).
REQ-006 SHALL have port: alu_op  out  5  ALU operation code to datapath.
REQ-007 SHALL have port: Run  out  1  high while executing; low in HALT.
REQ-008 SHALL have port: state  out  4  current state encoding, for debug.

Function
REQ-009 SHALL be a Moore FSM; ctrl/alu_op decoded combinationally from state and latched opcode only, one state per clock.
REQ-010 SHALL use states RESET, T0..T7, HALT.
REQ-011 SHALL fetch: T0 PC_out, MAR_enable, IncPC; T1 Read, MDR_enable; T2 MDR_out, IR_enable.
REQ-012 SHALL latch IR[31:27] into an internal opcode register at end of T2; execute states use the latched value.
REQ-013 SHALL run R-type ALU ops (add 00011, sub, and, or, ror, rol, shr, shra, shl): T3 Grb, R_out, Y_enable; T4 Grc, R_out, Z_enable, alu_op=opcode; T5 ZLow_out, Gra, R_in; then T0.
REQ-014 SHALL run addi/andi/ori: T3 Grb, BA_out, Y_enable; T4 C_out, Z_enable, alu_op = add 00011 / and 00101 / or 00110; T5 ZLow_out, Gra, R_in; then T0.
REQ-015 SHALL run neg/not: T3 Grb, R_out, Z_enable, alu_op=opcode; T4 ZLow_out, Gra, R_in; then T0.
REQ-016 SHALL run mul/div: T3 Gra, R_out, Y_enable; T4 Grb, R_out, Z_enable, alu_op=opcode; T5 ZLow_out, LO_enable; T6 ZHigh_out, HI_enable; then T0.
REQ-017 SHALL run ld: T3 Grb, BA_out, Y_enable; T4 C_out, Z_enable, alu_op=add; T5 ZLow_out, MAR_enable; T6 Read, MDR_enable; T7 MDR_out, Gra, R_in; then T0. ldi: T5 ZLow_out, Gra, R_in; then T0.
REQ-018 SHALL run st: T3-T5 as ld; T6 Gra, R_out, MDR_enable (Read=0); T7 RAM_write_enable; then T0.
REQ-019 SHALL run br: T3 Gra, R_out, con_in; T4 PC_out, Y_enable; T5 C_out, Z_enable, alu_op=add; T6 ZLow_out, and PC_enable only if CON_FF=1; then T0.
REQ-020 SHALL run mfhi/mflo: T3 HI_out/LO_out, Gra, R_in; in: T3 in_port_out, Gra, R_in; out: T3 Gra, R_out, out_port_enable; then T0.
REQ-021 SHALL treat nop and any undefined opcode as return to T0 after T2.
REQ-022 SHALL enter HALT after T2 on halt (11011), drive all ctrl=0, Run=0, and stay until reset.
REQ-023 SHALL never assert two bus drivers (*_out, BA_out, R_out) in the same state; alu_op=00000 when Z_enable=0.

Reset
REQ-024 SHALL on clr=0, asynchronously force state=RESET, opcode register=0, ctrl=0, alu_op=0, Run=1, including mid-instruction.
REQ-025 SHALL leave RESET for T0 on the first rising edge after clr deasserts.

Structure
REQ-026 SHALL place state encodings, opcode constants and ctrl bit indices in shared package cpu_pkg.
REQ-027 SHALL keep sub-module op_decode (opcode -> instruction class, alu_op) combinational, instantiated once.

Verification
REQ-028 SHALL check addi (IR=0x61180005 class addi): T3 Grb/BA_out/Y_enable; T4 C_out/Z_enable/alu_op=00011; T5 ZLow_out/Gra/R_in; next edge T0.
REQ-029 SHALL check br with CON_FF=0 -> T6 PC_enable=0; CON_FF=1 -> T6 PC_enable=1.
REQ-030 SHALL check st -> RAM_write_enable high only in T7, Read low throughout T6-T7.
REQ-031 SHALL check halt -> Run=0, ctrl=0 for 20 cycles; clr pulse low -> RESET, then T0.
REQ-032 SHALL check clr asserted during ld T5 -> outputs 0 immediately, no R_in pulse, restart at T0.
REQ-033 SHALL check undefined opcode 11111 -> T0 on edge after T2, no R_in/RAM_write_enable.
